// File: rtl/axi_ecc_wr_err_ctrl_if.sv
// rtl/axi_ecc_wr_err_ctrl_if.sv - AW/W handshake bundle between upstream bus, error controller and decoder master
interface axi_ecc_wr_err_ctrl_if #(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiIdWidth   = 4
);
    logic                    aw_valid_i;
    logic                    aw_ready_o;
    logic [AxiAddrWidth-1:0] aw_addr_i;
    logic [AxiIdWidth-1:0]   aw_id_i;
    logic                    aw_valid_o;
    logic                    aw_ready_i;
    logic                    w_valid_i;
    logic                    w_ready_o;
    logic                    w_last_i;
    logic                    w_valid_o;
    logic                    w_ready_i;

    modport slave (
        input  aw_valid_i, aw_addr_i, aw_id_i, aw_ready_i,
        input  w_valid_i, w_last_i, w_ready_i,
        output aw_ready_o, aw_valid_o, w_ready_o, w_valid_o
    );

    modport master (
        output aw_valid_i, aw_addr_i, aw_id_i, aw_ready_i,
        output w_valid_i, w_last_i, w_ready_i,
        input  aw_ready_o, aw_valid_o, w_ready_o, w_valid_o
    );
endinterface

// File: rtl/axi_ecc_wr_err_ctrl.sv
// rtl/axi_ecc_wr_err_ctrl.sv - write-side ECC controller: AW tracking, W gating, error counters, capture and IRQ
module axi_ecc_wr_err_ctrl #(
    parameter int unsigned AxiAddrWidth   = 32,
    parameter int unsigned AxiIdWidth     = 4,
    parameter int unsigned AxiDataWidth   = 32,
    parameter int unsigned AwDepth        = 4,
    parameter int unsigned CntWidth       = 16,
    parameter int unsigned CeIrqThreshold = 16,
    localparam int unsigned NbEccBits     = (AxiDataWidth == 64) ? 8 : 7
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    axi_ecc_wr_err_ctrl_if.slave    bus,
    input  logic [1:0]              err_i,
    input  logic [NbEccBits-1:0]    syndrome_i,
    input  logic                    clear_i,
    output logic [CntWidth-1:0]     ce_cnt_o,
    output logic [CntWidth-1:0]     ue_cnt_o,
    output logic                    cap_valid_o,
    output logic                    cap_ue_o,
    output logic [AxiAddrWidth-1:0] cap_addr_o,
    output logic [AxiIdWidth-1:0]   cap_id_o,
    output logic [7:0]              cap_beat_o,
    output logic [NbEccBits-1:0]    cap_syndrome_o,
    output logic                    irq_o
);
    localparam int unsigned PtrW = $clog2(AwDepth);
    typedef logic [PtrW:0] ptr_t;

    if (!(AxiDataWidth == 32 || AxiDataWidth == 64)) begin : g_bad_data_width
        $fatal(1, "axi_ecc_wr_err_ctrl: AxiDataWidth must be 32 or 64");
    end
    if (AwDepth < 2 || (AwDepth & (AwDepth - 1)) != 0) begin : g_bad_aw_depth
        $fatal(1, "axi_ecc_wr_err_ctrl: AwDepth must be a power of two >= 2");
    end
    if (CeIrqThreshold < 1) begin : g_bad_threshold
        $fatal(1, "axi_ecc_wr_err_ctrl: CeIrqThreshold must be >= 1");
    end

    ptr_t                    wr_ptr_q, wr_ptr_d;
    ptr_t                    rd_ptr_q, rd_ptr_d;
    logic [AxiAddrWidth-1:0] addr_mem_q [AwDepth];
    logic [AxiAddrWidth-1:0] addr_mem_d [AwDepth];
    logic [AxiIdWidth-1:0]   id_mem_q   [AwDepth];
    logic [AxiIdWidth-1:0]   id_mem_d   [AwDepth];
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [CntWidth-1:0]     ce_cnt_q, ce_cnt_d;
    logic [CntWidth-1:0]     ue_cnt_q, ue_cnt_d;
    logic                    irq_q, irq_d;
    logic                    cap_valid_q, cap_valid_d;
    logic                    cap_ue_q, cap_ue_d;
    logic [AxiAddrWidth-1:0] cap_addr_q, cap_addr_d;
    logic [AxiIdWidth-1:0]   cap_id_q, cap_id_d;
    logic [7:0]              cap_beat_q, cap_beat_d;
    logic [NbEccBits-1:0]    cap_syn_q, cap_syn_d;

    logic [PtrW-1:0] wr_idx, rd_idx;
    logic            full, empty, push, beat, pop;
    logic            ce_hit, ue_hit, ce_thr_hit, cap_load;

    assign wr_idx = wr_ptr_q[PtrW-1:0];
    assign rd_idx = rd_ptr_q[PtrW-1:0];

    // Full/empty come from registered pointers only, so a same-cycle pop never frees a slot.
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign bus.aw_valid_o = bus.aw_valid_i & ~full;
    assign bus.aw_ready_o = bus.aw_ready_i & ~full;
    assign bus.w_valid_o  = bus.w_valid_i & ~empty;
    assign bus.w_ready_o  = bus.w_ready_i & ~empty;

    assign push   = bus.aw_valid_i & bus.aw_ready_i & ~full;
    assign beat   = bus.w_valid_i & bus.w_ready_i & ~empty;
    assign pop    = beat & bus.w_last_i;
    assign ue_hit = beat & err_i[1];
    assign ce_hit = beat & (err_i == 2'b01);

    // AW tracking FIFO: push on downstream AW handshake, pop on the last W beat.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + ptr_t'(push);
        rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
        addr_mem_d = addr_mem_q;
        id_mem_d   = id_mem_q;
        if (push) begin
            addr_mem_d[wr_idx] = bus.aw_addr_i;
            id_mem_d[wr_idx]   = bus.aw_id_i;
        end
    end

    // Beat index within the current burst; wraps silently past 256 beats.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (beat) begin
            beat_cnt_d = bus.w_last_i ? 8'd0 : beat_cnt_q + 8'd1;
        end
    end

    // Saturating error counters and sticky IRQ; a same-cycle clear is applied first.
    always_comb begin
        ce_cnt_d = clear_i ? '0 : ce_cnt_q;
        ue_cnt_d = clear_i ? '0 : ue_cnt_q;
        if (ce_hit && (ce_cnt_d != '1)) begin
            ce_cnt_d = ce_cnt_d + CntWidth'(1);
        end
        if (ue_hit && (ue_cnt_d != '1)) begin
            ue_cnt_d = ue_cnt_d + CntWidth'(1);
        end
        ce_thr_hit = ce_hit && (32'(ce_cnt_d) == CeIrqThreshold);
        irq_d      = (clear_i ? 1'b0 : irq_q) | ue_hit | ce_thr_hit;
    end

    // Capture the first error, upgrade once to the first uncorrectable one, then hold.
    always_comb begin
        cap_valid_d = clear_i ? 1'b0 : cap_valid_q;
        cap_ue_d    = clear_i ? 1'b0 : cap_ue_q;
        cap_addr_d  = clear_i ? '0 : cap_addr_q;
        cap_id_d    = clear_i ? '0 : cap_id_q;
        cap_beat_d  = clear_i ? '0 : cap_beat_q;
        cap_syn_d   = clear_i ? '0 : cap_syn_q;
        cap_load    = (ce_hit | ue_hit) & (~cap_valid_d | (ue_hit & ~cap_ue_d));
        if (cap_load) begin
            cap_valid_d = 1'b1;
            cap_ue_d    = ue_hit;
            cap_addr_d  = addr_mem_q[rd_idx];
            cap_id_d    = id_mem_q[rd_idx];
            cap_beat_d  = beat_cnt_q;
            cap_syn_d   = syndrome_i;
        end
    end

    // State registers; reset discards every tracked burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < int'(AwDepth); i++) begin
                addr_mem_q[i] <= '0;
                id_mem_q[i]   <= '0;
            end
            beat_cnt_q  <= '0;
            ce_cnt_q    <= '0;
            ue_cnt_q    <= '0;
            irq_q       <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_ue_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_id_q    <= '0;
            cap_beat_q  <= '0;
            cap_syn_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            addr_mem_q  <= addr_mem_d;
            id_mem_q    <= id_mem_d;
            beat_cnt_q  <= beat_cnt_d;
            ce_cnt_q    <= ce_cnt_d;
            ue_cnt_q    <= ue_cnt_d;
            irq_q       <= irq_d;
            cap_valid_q <= cap_valid_d;
            cap_ue_q    <= cap_ue_d;
            cap_addr_q  <= cap_addr_d;
            cap_id_q    <= cap_id_d;
            cap_beat_q  <= cap_beat_d;
            cap_syn_q   <= cap_syn_d;
        end
    end

    assign ce_cnt_o       = ce_cnt_q;
    assign ue_cnt_o       = ue_cnt_q;
    assign irq_o          = irq_q;
    assign cap_valid_o    = cap_valid_q;
    assign cap_ue_o       = cap_ue_q;
    assign cap_addr_o     = cap_addr_q;
    assign cap_id_o       = cap_id_q;
    assign cap_beat_o     = cap_beat_q;
    assign cap_syndrome_o = cap_syn_q;
endmodule

// File: tb/tb_axi_ecc_wr_err_ctrl.sv
// tb/tb_axi_ecc_wr_err_ctrl.sv - randomized and directed bench with a queue-based reference model
module tb_axi_ecc_wr_err_ctrl;
    localparam int AW    = 32;
    localparam int IW    = 4;
    localparam int NB    = 7;
    localparam int DEPTH = 4;
    localparam int THR   = 16;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] err;
    logic [NB-1:0] syn;
    logic clear;

    always #5 clk = ~clk;

    axi_ecc_wr_err_ctrl_if #(.AxiAddrWidth(AW), .AxiIdWidth(IW)) bus ();
    axi_ecc_wr_err_ctrl_if #(.AxiAddrWidth(AW), .AxiIdWidth(IW)) bus_b ();

    assign bus_b.aw_valid_i = bus.aw_valid_i;
    assign bus_b.aw_addr_i  = bus.aw_addr_i;
    assign bus_b.aw_id_i    = bus.aw_id_i;
    assign bus_b.aw_ready_i = bus.aw_ready_i;
    assign bus_b.w_valid_i  = bus.w_valid_i;
    assign bus_b.w_last_i   = bus.w_last_i;
    assign bus_b.w_ready_i  = bus.w_ready_i;

    logic [15:0] ce_a, ue_a;
    logic [3:0]  ce_b, ue_b;
    logic        cv_a, cue_a, irq_a, cv_b, cue_b, irq_b;
    logic [AW-1:0] caddr_a, caddr_b;
    logic [IW-1:0] cid_a, cid_b;
    logic [7:0]    cbeat_a, cbeat_b;
    logic [NB-1:0] csyn_a, csyn_b;

    axi_ecc_wr_err_ctrl #(
        .AxiAddrWidth(AW), .AxiIdWidth(IW), .AxiDataWidth(32),
        .AwDepth(DEPTH), .CntWidth(16), .CeIrqThreshold(THR)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus), .err_i(err), .syndrome_i(syn),
        .clear_i(clear), .ce_cnt_o(ce_a), .ue_cnt_o(ue_a), .cap_valid_o(cv_a),
        .cap_ue_o(cue_a), .cap_addr_o(caddr_a), .cap_id_o(cid_a), .cap_beat_o(cbeat_a),
        .cap_syndrome_o(csyn_a), .irq_o(irq_a)
    );

    axi_ecc_wr_err_ctrl #(
        .AxiAddrWidth(AW), .AxiIdWidth(IW), .AxiDataWidth(32),
        .AwDepth(DEPTH), .CntWidth(4), .CeIrqThreshold(THR)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b), .err_i(err), .syndrome_i(syn),
        .clear_i(clear), .ce_cnt_o(ce_b), .ue_cnt_o(ue_b), .cap_valid_o(cv_b),
        .cap_ue_o(cue_b), .cap_addr_o(caddr_b), .cap_id_o(cid_b), .cap_beat_o(cbeat_b),
        .cap_syndrome_o(csyn_b), .irq_o(irq_b)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: burst queue, beat index, counts and capture record.
    logic [AW+IW-1:0] m_q[$];
    int            m_bidx = 0;
    int            m_ce_a = 0, m_ue_a = 0, m_ce_b = 0, m_ue_b = 0;
    bit            m_irq_a = 0, m_irq_b = 0, m_cv = 0, m_cue = 0;
    logic [AW-1:0] m_caddr = '0;
    logic [IW-1:0] m_cid = '0;
    int            m_cbeat = 0;
    logic [NB-1:0] m_csyn = '0;

    function automatic void model_clear_status();
        m_ce_a = 0; m_ue_a = 0; m_ce_b = 0; m_ue_b = 0;
        m_irq_a = 0; m_irq_b = 0;
        m_cv = 0; m_cue = 0; m_caddr = '0; m_cid = '0; m_cbeat = 0; m_csyn = '0;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_bidx = 0;
        model_clear_status();
    endfunction

    function automatic void model_step();
        bit full   = (m_q.size() == DEPTH);
        bit empty  = (m_q.size() == 0);
        bit push   = bus.aw_valid_i && bus.aw_ready_i && !full;
        bit beat   = bus.w_valid_i && bus.w_ready_i && !empty;
        bit is_ue  = beat && err[1];
        bit is_ce  = beat && (err == 2'b01);
        if (clear) model_clear_status();
        if (is_ue) begin
            if (m_ue_a < MAX_A) m_ue_a++;
            if (m_ue_b < MAX_B) m_ue_b++;
            m_irq_a = 1; m_irq_b = 1;
        end
        if (is_ce) begin
            if (m_ce_a < MAX_A) m_ce_a++;
            if (m_ce_b < MAX_B) m_ce_b++;
        end
        if (m_ce_a >= THR) m_irq_a = 1;
        if (m_ce_b >= THR) m_irq_b = 1;
        if ((is_ue || is_ce) && (!m_cv || (is_ue && !m_cue))) begin
            m_cv    = 1;
            m_cue   = is_ue;
            m_caddr = m_q[0][AW+IW-1:IW];
            m_cid   = m_q[0][IW-1:0];
            m_cbeat = m_bidx;
            m_csyn  = syn;
        end
        if (beat) begin
            if (bus.w_last_i) begin
                void'(m_q.pop_front());
                m_bidx = 0;
            end else begin
                m_bidx = (m_bidx + 1) % 256;
            end
        end
        if (push) m_q.push_back({bus.aw_addr_i, bus.aw_id_i});
    endfunction

    function automatic void compare();
        bit full  = (m_q.size() == DEPTH);
        bit empty = (m_q.size() == 0);
        chk("aw_valid_o", bus.aw_valid_o, bus.aw_valid_i && !full);
        chk("aw_ready_o", bus.aw_ready_o, bus.aw_ready_i && !full);
        chk("w_valid_o", bus.w_valid_o, bus.w_valid_i && !empty);
        chk("w_ready_o", bus.w_ready_o, bus.w_ready_i && !empty);
        chk("ce_cnt_a", ce_a, m_ce_a);
        chk("ue_cnt_a", ue_a, m_ue_a);
        chk("irq_a", irq_a, m_irq_a);
        chk("cap_valid_a", cv_a, m_cv);
        chk("cap_ue_a", cue_a, m_cue);
        chk("cap_addr_a", caddr_a, m_caddr);
        chk("cap_id_a", cid_a, m_cid);
        chk("cap_beat_a", cbeat_a, m_cbeat);
        chk("cap_syn_a", csyn_a, m_csyn);
        chk("b_aw_ready_o", bus_b.aw_ready_o, bus.aw_ready_i && !full);
        chk("b_aw_valid_o", bus_b.aw_valid_o, bus.aw_valid_i && !full);
        chk("b_w_ready_o", bus_b.w_ready_o, bus.w_ready_i && !empty);
        chk("b_w_valid_o", bus_b.w_valid_o, bus.w_valid_i && !empty);
        chk("ce_cnt_b", ce_b, m_ce_b);
        chk("ue_cnt_b", ue_b, m_ue_b);
        chk("irq_b", irq_b, m_irq_b);
        chk("cap_valid_b", cv_b, m_cv);
        chk("cap_ue_b", cue_b, m_cue);
        chk("cap_addr_b", caddr_b, m_caddr);
        chk("cap_id_b", cid_b, m_cid);
        chk("cap_beat_b", cbeat_b, m_cbeat);
        chk("cap_syn_b", csyn_b, m_csyn);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        compare();
        if (rst_n) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.aw_valid_i = 0; bus.aw_ready_i = 0; bus.aw_addr_i = '0; bus.aw_id_i = '0;
        bus.w_valid_i = 0; bus.w_ready_i = 0; bus.w_last_i = 0;
        err = 2'b00; syn = '0; clear = 0;
    endtask

    task automatic do_aw(input logic [AW-1:0] addr, input logic [IW-1:0] id);
        bus.aw_valid_i = 1; bus.aw_ready_i = 1; bus.aw_addr_i = addr; bus.aw_id_i = id;
        #1;
        chk("aw_accept", bus.aw_ready_o, 1);
        tick();
        bus.aw_valid_i = 0; bus.aw_ready_i = 0;
    endtask

    task automatic do_beat(input bit last, input logic [1:0] e, input logic [NB-1:0] s, input bit clr);
        bus.w_valid_i = 1; bus.w_ready_i = 1; bus.w_last_i = last;
        err = e; syn = s; clear = clr;
        #1;
        chk("w_accept", bus.w_ready_o, 1);
        tick();
        bus.w_valid_i = 0; bus.w_ready_i = 0; bus.w_last_i = 0;
        err = 2'b00; syn = '0; clear = 0;
    endtask

    initial begin
        rst_n = 0;
        idle();
        repeat (3) tick();
        chk("rst_ce", ce_a, 0);
        chk("rst_irq", irq_a, 0);
        chk("rst_cap_valid", cv_a, 0);
        chk("rst_w_ready", bus.w_ready_o, 0);
        rst_n = 1;
        tick();

        // single burst, CE on beat 2
        do_aw(32'h1000, 4'd3);
        do_beat(0, 2'b00, '0, 0);
        do_beat(0, 2'b00, '0, 0);
        do_beat(0, 2'b01, 7'h15, 0);
        chk("s1_ce", ce_a, 1);
        chk("s1_cap_valid", cv_a, 1);
        chk("s1_cap_ue", cue_a, 0);
        chk("s1_cap_addr", caddr_a, 32'h1000);
        chk("s1_cap_id", cid_a, 3);
        chk("s1_cap_beat", cbeat_a, 2);
        chk("s1_cap_syn", csyn_a, 7'h15);
        chk("s1_irq", irq_a, 0);
        do_beat(1, 2'b00, '0, 0);

        // CE capture upgraded by UE, later UE ignored
        do_aw(32'h2000, 4'd5);
        do_beat(0, 2'b10, 7'h2A, 0);
        chk("s2_cap_addr", caddr_a, 32'h2000);
        chk("s2_cap_id", cid_a, 5);
        chk("s2_cap_beat", cbeat_a, 0);
        chk("s2_cap_ue", cue_a, 1);
        chk("s2_irq", irq_a, 1);
        chk("s2_ue", ue_a, 1);
        do_beat(1, 2'b11, 7'h11, 0);
        chk("s2_sticky_syn", csyn_a, 7'h2A);
        chk("s2_sticky_beat", cbeat_a, 0);
        chk("s2_ue2", ue_a, 2);

        // W before AW
        bus.w_valid_i = 1; bus.w_ready_i = 1; bus.w_last_i = 1;
        #1;
        chk("wb_ready0", bus.w_ready_o, 0);
        chk("wb_valid0", bus.w_valid_o, 0);
        tick();
        chk("wb_ready1", bus.w_ready_o, 0);
        bus.aw_valid_i = 1; bus.aw_ready_i = 1; bus.aw_addr_i = 32'h5000; bus.aw_id_i = 4'd7;
        tick();
        bus.aw_valid_i = 0; bus.aw_ready_i = 0;
        #1;
        chk("wb_valid_after", bus.w_valid_o, 1);
        chk("wb_ready_after", bus.w_ready_o, 1);
        tick();
        idle();
        #1;
        chk("wb_empty_again", bus.w_valid_o, 0);

        // FIFO full
        for (int i = 0; i < 4; i++) do_aw(32'h6000 + 32'(i * 16), 4'(i));
        bus.aw_valid_i = 1; bus.aw_ready_i = 1; bus.aw_addr_i = 32'h7000; bus.aw_id_i = 4'd9;
        #1;
        chk("full_aw_ready", bus.aw_ready_o, 0);
        chk("full_aw_valid", bus.aw_valid_o, 0);
        bus.w_valid_i = 1; bus.w_ready_i = 1; bus.w_last_i = 1;
        #1;
        chk("full_same_cycle_pop", bus.aw_ready_o, 0);
        tick();
        bus.w_valid_i = 0; bus.w_ready_i = 0; bus.w_last_i = 0;
        #1;
        chk("full_freed", bus.aw_ready_o, 1);
        tick();
        bus.aw_valid_i = 0; bus.aw_ready_i = 0;
        for (int i = 0; i < 4; i++) do_beat(1, 2'b00, '0, 0);

        // clear
        clear = 1;
        tick();
        clear = 0;
        #1;
        chk("clr_ce", ce_a, 0);
        chk("clr_ue", ue_a, 0);
        chk("clr_cap_valid", cv_a, 0);
        chk("clr_irq", irq_a, 0);

        // threshold and saturation
        do_aw(32'h3000, 4'd1);
        for (int i = 1; i <= 20; i++) begin
            do_beat(i == 20, 2'b01, 7'(i), 0);
            if (i == 15) chk("thr_irq_15", irq_a, 0);
            if (i == 16) begin
                chk("thr_irq_16", irq_a, 1);
                chk("thr_ce_16", ce_a, 16);
            end
        end
        chk("sat_ce_a", ce_a, 20);
        chk("sat_ce_b", ce_b, 15);
        chk("sat_irq_b", irq_b, 0);
        chk("thr_cap_beat", cbeat_a, 0);
        chk("thr_cap_syn", csyn_a, 1);

        // clear collides with a UE beat
        do_aw(32'h4000, 4'd2);
        do_beat(1, 2'b10, 7'h33, 1);
        chk("col_ue", ue_a, 1);
        chk("col_ce", ce_a, 0);
        chk("col_cap_ue", cue_a, 1);
        chk("col_irq", irq_a, 1);
        chk("col_cap_addr", caddr_a, 32'h4000);
        chk("col_ue_b", ue_b, 1);

        // reset mid-burst
        do_aw(32'h8000, 4'd4);
        do_beat(0, 2'b01, 7'h05, 0);
        rst_n = 0;
        bus.w_valid_i = 1; bus.w_ready_i = 1;
        #1;
        chk("mrst_ce", ce_a, 0);
        chk("mrst_ue", ue_a, 0);
        chk("mrst_irq", irq_a, 0);
        chk("mrst_cap_valid", cv_a, 0);
        chk("mrst_w_ready", bus.w_ready_o, 0);
        tick();
        idle();
        rst_n = 1;
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            bus.aw_valid_i = ($urandom_range(0, 9) < 6);
            bus.aw_ready_i = ($urandom_range(0, 9) < 7);
            bus.aw_addr_i  = $urandom;
            bus.aw_id_i    = 4'($urandom);
            bus.w_valid_i  = ($urandom_range(0, 9) < 6);
            bus.w_ready_i  = ($urandom_range(0, 9) < 7);
            bus.w_last_i   = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            err = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            syn = 7'($urandom);
            clear = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
